neuron_update_sequencer: RTL and testbench
==========================================

Name: neuron_update_sequencer

Overview:
Time-multiplexed membrane-potential update engine for a small layer of integrate-and-fire neurons. It shares one signed saturating adder (two's-complement, clamps to MAX/MIN on overflow) across NEURONS potentials. For each neuron it applies input current, then leak, then a threshold/fire check. It sits between the layer's input-current source and the spike output bus, and is kicked once per network timestep.

Parameters:
NEURONS, 4, number of neurons sequenced; potentials are held in internal registers.
WIDTH, 8, bit width of a signed potential and of a signed current.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request one timestep update; sampled only in IDLE.
in_current  input  NEURONS*WIDTH  signed per-neuron current; neuron i occupies bits [i*WIDTH +: WIDTH].
leak  input  WIDTH-1  unsigned leak magnitude, subtracted once per neuron per timestep.
threshold  input  WIDTH  signed firing threshold.
busy  output  1  high while a timestep is in progress.
done  output  1  single-cycle pulse marking timestep completion.
spikes  output  NEURONS  spike vector of the last completed timestep; bit i = neuron i.
potentials  output  NEURONS*WIDTH  current signed potentials, same packing as in_current.

Behaviour:
- Reset (async, active-high): all potentials 0, spikes 0, busy 0, done 0, FSM to IDLE, neuron index 0. Reset mid-run aborts the run with no done pulse and no spike update.
- Saturation: MAX = 2^(WIDTH-1)-1, MIN = -2^(WIDTH-1). Overflow occurs when the operands share a sign and the sum's sign differs. Result is MAX if the operand is non-negative, MIN otherwise. There is exactly one adder instance, time-shared.
- Capture: on the edge that accepts start, latch in_current, leak and threshold into snapshot registers. Input changes during the run have no effect.
- FSM states: IDLE, INPUT, LEAK, DONE.
  - IDLE: busy=0. If start=1, capture snapshots, set idx=0, go to INPUT.
  - INPUT: busy=1. temp = sat(pot[idx] + cur[idx]). Go to LEAK.
  - LEAK: busy=1. r = sat(temp + (-zero_extend(leak))). The negated leak is never below -MAX, so negation itself cannot overflow.
    - If r >= threshold (signed compare): set shadow spike bit idx = 1 and write pot[idx] = 0.
    - Otherwise: clear shadow spike bit idx and write pot[idx] = r.
    - If idx = NEURONS-1, go to DONE; else idx++ and go to INPUT.
  - DONE: busy=0, done=1 for this one cycle; spikes <= shadow vector. Go to IDLE.
- Latency: start accepted at edge k. busy is high from after edge k until after edge k+2*NEURONS. done is high for the one cycle following edge k+2*NEURONS. With NEURONS=4 that is 8 cycles busy, then the done cycle.
- start in INPUT, LEAK or DONE is ignored and not queued. start held high continuously yields back-to-back runs separated by one IDLE cycle.
- potentials output reflects register contents live; writes become visible one neuron at a time after each LEAK edge. spikes changes only in DONE and holds until the next DONE or reset.
- Neurons are processed in ascending index order. A neuron's update never reads another neuron's result.
- The threshold compare uses the saturated post-leak value. A neuron that fires resets to 0 regardless of any overshoot.

Test Plan:
1. Reset: assert reset with random inputs -> potentials all 0, spikes=0, busy=0, done=0; deassert -> FSM idle, outputs unchanged.
2. Single timestep (WIDTH=8, NEURONS=4): currents {10,20,30,40}, leak=5, threshold=100, pulse start -> busy high 8 cycles, done pulse on 9th, potentials {5,15,25,35}, spikes=4'b0000.
3. Fire: repeat scenario 2 twice more (3 timesteps total) -> after third done, potentials {15,45,75,0}, spikes=4'b1000. A fourth timestep with zero currents and leak 0 -> spikes=4'b0000.
4. Saturation: neuron0 current 127, leak=1, threshold=127, two timesteps -> potential 126 after each (second sum clamps to 127 before leak), spikes bit0=0. Neuron1 current -128, leak=127, two timesteps -> potential -128 both times, no wrap to positive.
5. Start while busy: start held for 3 cycles, or re-pulsed at cycle 4 of a run -> exactly one done per accepted start. Input change mid-run (currents changed at cycle 2) does not alter results versus scenario 2.
6. Reset mid-operation: assert reset at cycle 5 of a run -> no done pulse, potentials 0, spikes 0. A subsequent start completes normally with scenario 2 values.

Source files
------------

// File: rtl/neuron_update_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : neuron_update_sequencer_if
// Description : Control/data bundle between the layer current source, the
//               neuron update sequencer and the spike output bus.
// Revision    : 1.0 - initial release
// ============================================================================
interface neuron_update_sequencer_if #(
  parameter int NEURONS = 4,
  parameter int WIDTH   = 8
);
  logic                       start;
  logic [NEURONS*WIDTH-1:0]   in_current;
  logic [WIDTH-2:0]           leak;
  logic [WIDTH-1:0]           threshold;
  logic                       busy;
  logic                       done;
  logic [NEURONS-1:0]         spikes;
  logic [NEURONS*WIDTH-1:0]   potentials;

  // Requester side: drives the timestep kick and its operands.
  modport master (
    output start, in_current, leak, threshold,
    input  busy, done, spikes, potentials
  );

  // Sequencer side.
  modport slave (
    input  start, in_current, leak, threshold,
    output busy, done, spikes, potentials
  );
endinterface
`default_nettype wire

// File: rtl/neuron_update_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : neuron_update_sequencer
// Description : Time-multiplexed integrate-and-fire membrane update engine.
//               One signed saturating adder is shared across all neurons:
//               per neuron, add input current, subtract leak, then compare
//               against threshold and fire/reset.
// Revision    : 1.0 - initial release
// ============================================================================
module neuron_update_sequencer #(
  parameter int NEURONS = 4,
  parameter int WIDTH   = 8
) (
  input  wire                         clk,
  input  wire                         reset,
  neuron_update_sequencer_if.slave    bus
);

  localparam int IDX_W = (NEURONS > 1) ? $clog2(NEURONS) : 1;

  localparam logic signed [WIDTH-1:0] c_max = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] c_min = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [IDX_W-1:0]        c_last_idx = IDX_W'(NEURONS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_INPUT = 2'd1,
    S_LEAK  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                   r_state;
  logic [IDX_W-1:0]         r_idx;
  logic signed [WIDTH-1:0]  r_pot [NEURONS];
  logic signed [WIDTH-1:0]  r_cur [NEURONS];
  logic [WIDTH-2:0]         r_leak;
  logic signed [WIDTH-1:0]  r_thr;
  logic signed [WIDTH-1:0]  r_temp;
  logic [NEURONS-1:0]       r_shadow;
  logic [NEURONS-1:0]       r_spikes;
  logic                     r_busy;
  logic                     r_done;

  logic signed [WIDTH-1:0]  w_add_a;
  logic signed [WIDTH-1:0]  w_add_b;
  logic signed [WIDTH-1:0]  w_sum;
  logic signed [WIDTH-1:0]  w_neg_leak;
  logic                     w_fire;
  logic [NEURONS-1:0]       w_shadow_next;

  // Two's-complement add that clamps on same-sign overflow.
  function automatic logic signed [WIDTH-1:0] sat_add(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    logic signed [WIDTH-1:0] s;
    s = a + b;
    if ((a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]))
      return a[WIDTH-1] ? c_min : c_max;
    return s;
  endfunction

  // Leak is at most MAX, so its negation always fits.
  assign w_neg_leak = WIDTH'(0) - WIDTH'({1'b0, r_leak});

  // Operand mux for the single shared adder: current in INPUT, leak otherwise.
  always_comb begin
    w_add_a = r_temp;
    w_add_b = w_neg_leak;
    if (r_state == S_INPUT) begin
      w_add_a = r_pot[r_idx];
      w_add_b = r_cur[r_idx];
    end
  end

  assign w_sum  = sat_add(w_add_a, w_add_b);
  assign w_fire = (w_sum >= r_thr);

  // Shadow spike vector including the neuron being resolved this cycle.
  always_comb begin
    w_shadow_next        = r_shadow;
    w_shadow_next[r_idx] = w_fire;
  end

  // Sequencer FSM with registered outputs. The public spike vector is
  // published on the edge entering DONE so it is valid alongside the pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_leak   <= '0;
      r_thr    <= '0;
      r_temp   <= '0;
      r_shadow <= '0;
      r_spikes <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      for (int i = 0; i < NEURONS; i++) begin
        r_pot[i] <= '0;
        r_cur[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            for (int i = 0; i < NEURONS; i++)
              r_cur[i] <= bus.in_current[i*WIDTH +: WIDTH];
            r_leak  <= bus.leak;
            r_thr   <= bus.threshold;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_INPUT;
          end
        end
        S_INPUT: begin
          r_temp  <= w_sum;
          r_state <= S_LEAK;
        end
        S_LEAK: begin
          r_shadow     <= w_shadow_next;
          r_pot[r_idx] <= w_fire ? '0 : w_sum;
          if (r_idx == c_last_idx) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_spikes <= w_shadow_next;
            r_state  <= S_DONE;
          end else begin
            r_idx   <= r_idx + IDX_W'(1);
            r_state <= S_INPUT;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.spikes = r_spikes;

  generate
    for (genvar gi = 0; gi < NEURONS; gi++) begin : g_pack
      assign bus.potentials[gi*WIDTH +: WIDTH] = r_pot[gi];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_neuron_update_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_neuron_update_sequencer
// Description : Directed self-checking bench for neuron_update_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_neuron_update_sequencer;

  localparam int NEURONS = 4;
  localparam int WIDTH   = 8;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;
  int   done_cnt;

  neuron_update_sequencer_if #(.NEURONS(NEURONS), .WIDTH(WIDTH)) u_if ();

  neuron_update_sequencer #(.NEURONS(NEURONS), .WIDTH(WIDTH)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count done pulses, sampled away from the active edge.
  always @(negedge clk) if (u_if.done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] pack4(input logic [7:0] n0, input logic [7:0] n1,
                                        input logic [7:0] n2, input logic [7:0] n3);
    return {n3, n2, n1, n0};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // One pulsed timestep; checks busy length and the done pulse.
  task automatic do_step(input logic [31:0] cur, input logic [6:0] lk, input logic [7:0] th);
    int busy_cnt;
    int guard;
    @(negedge clk);
    u_if.in_current = cur;
    u_if.leak       = lk;
    u_if.threshold  = th;
    u_if.start      = 1'b1;
    @(negedge clk);
    u_if.start = 1'b0;
    busy_cnt = 0;
    guard    = 0;
    while (u_if.busy === 1'b1 && guard < 40) begin
      busy_cnt++;
      guard++;
      @(negedge clk);
    end
    check("busy_cycles", busy_cnt, 8);
    check("done_pulse", {31'd0, u_if.done}, 1);
    @(negedge clk);
    check("done_low", {31'd0, u_if.done}, 0);
  endtask

  initial begin
    int d0;
    n_checks = 0;
    n_pass   = 0;
    done_cnt = 0;
    reset    = 1'b1;
    u_if.start      = 1'b0;
    u_if.in_current = $urandom;
    u_if.leak       = 7'($urandom);
    u_if.threshold  = 8'($urandom);

    // 1. Reset state with random inputs
    repeat (3) @(negedge clk);
    check("rst_pot",    u_if.potentials, 0);
    check("rst_spikes", {28'd0, u_if.spikes}, 0);
    check("rst_busy",   {31'd0, u_if.busy}, 0);
    check("rst_done",   {31'd0, u_if.done}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_busy", {31'd0, u_if.busy}, 0);
    check("post_rst_pot",  u_if.potentials, 0);

    // 2/3. Three timesteps, last fires neuron 3; then a quiet step
    do_step(pack4(10, 20, 30, 40), 7'd5, 8'd100);
    check("ts1_pot",    u_if.potentials, pack4(5, 15, 25, 35));
    check("ts1_spikes", {28'd0, u_if.spikes}, 0);
    do_step(pack4(10, 20, 30, 40), 7'd5, 8'd100);
    check("ts2_pot",    u_if.potentials, pack4(10, 30, 50, 70));
    do_step(pack4(10, 20, 30, 40), 7'd5, 8'd100);
    check("ts3_pot",    u_if.potentials, pack4(15, 45, 75, 0));
    check("ts3_spikes", {28'd0, u_if.spikes}, 32'h8);
    do_step(pack4(0, 0, 0, 0), 7'd0, 8'd100);
    check("ts4_pot",    u_if.potentials, pack4(15, 45, 75, 0));
    check("ts4_spikes", {28'd0, u_if.spikes}, 0);

    // 4a. Positive saturation on neuron 0
    do_reset();
    do_step(pack4(127, 0, 0, 0), 7'd1, 8'd127);
    check("satp1_pot", u_if.potentials, pack4(126, 8'hFF, 8'hFF, 8'hFF));
    do_step(pack4(127, 0, 0, 0), 7'd1, 8'd127);
    check("satp2_pot",    u_if.potentials, pack4(126, 8'hFE, 8'hFE, 8'hFE));
    check("satp2_spikes", {28'd0, u_if.spikes}, 0);

    // 4b. Negative saturation on neuron 1 with maximum leak
    do_reset();
    do_step(pack4(0, 8'h80, 0, 0), 7'd127, 8'd127);
    check("satn1_pot", u_if.potentials, pack4(8'h81, 8'h80, 8'h81, 8'h81));
    do_step(pack4(0, 8'h80, 0, 0), 7'd127, 8'd127);
    check("satn2_pot", u_if.potentials, pack4(8'h80, 8'h80, 8'h80, 8'h80));

    // Threshold boundaries: equality fires; negative threshold is signed
    do_reset();
    do_step(pack4(50, 0, 0, 0), 7'd0, 8'd50);
    check("thr_eq_spikes", {28'd0, u_if.spikes}, 32'h1);
    check("thr_eq_pot",    u_if.potentials, 0);
    do_step(pack4(0, 0, 0, 0), 7'd0, 8'hFF);
    check("thr_neg_spikes", {28'd0, u_if.spikes}, 32'hF);

    // 5a. start held for 3 cycles -> one run
    do_reset();
    d0 = done_cnt;
    u_if.in_current = pack4(10, 20, 30, 40);
    u_if.leak       = 7'd5;
    u_if.threshold  = 8'd100;
    u_if.start      = 1'b1;
    repeat (3) @(negedge clk);
    u_if.start = 1'b0;
    repeat (14) @(negedge clk);
    check("hold3_dones", done_cnt - d0, 1);
    check("hold3_pot",   u_if.potentials, pack4(5, 15, 25, 35));

    // 5b. re-pulse at cycle 4 and change currents at cycle 2
    do_reset();
    d0 = done_cnt;
    u_if.in_current = pack4(10, 20, 30, 40);
    u_if.start      = 1'b1;
    @(negedge clk);
    u_if.start = 1'b0;
    @(negedge clk);
    u_if.in_current = pack4(99, 99, 99, 99);
    u_if.leak       = 7'd0;
    repeat (2) @(negedge clk);
    u_if.start = 1'b1;
    @(negedge clk);
    u_if.start = 1'b0;
    repeat (12) @(negedge clk);
    check("repulse_dones", done_cnt - d0, 1);
    check("repulse_pot",   u_if.potentials, pack4(5, 15, 25, 35));

    // Continuous start -> back-to-back runs with one IDLE cycle between
    do_reset();
    d0 = done_cnt;
    u_if.in_current = pack4(10, 20, 30, 40);
    u_if.leak       = 7'd5;
    u_if.start      = 1'b1;
    repeat (20) @(negedge clk);
    u_if.start = 1'b0;
    repeat (12) @(negedge clk);
    check("b2b_dones", done_cnt - d0, 2);
    check("b2b_pot",   u_if.potentials, pack4(10, 30, 50, 70));

    // 6. Reset mid-run: spikes made non-zero first so the clear is visible
    do_step(pack4(0, 0, 0, 0), 7'd0, 8'hFF);
    check("pre_abort_spikes", {28'd0, u_if.spikes}, 32'hF);
    d0 = done_cnt;
    u_if.in_current = pack4(10, 20, 30, 40);
    u_if.leak       = 7'd5;
    u_if.threshold  = 8'd100;
    u_if.start      = 1'b1;
    @(negedge clk);
    u_if.start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_pot",    u_if.potentials, 0);
    check("abort_spikes", {28'd0, u_if.spikes}, 0);
    check("abort_busy",   {31'd0, u_if.busy}, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    do_step(pack4(10, 20, 30, 40), 7'd5, 8'd100);
    check("after_abort_pot", u_if.potentials, pack4(5, 15, 25, 35));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
